banked_memory: RTL and testbench
================================

BANKED_MEMORY -- requirements
Module: banked_memory

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, word width in bits; ADDR_W, default 12, byte-address width; NUM_BANKS, default 4, power of two, bank count; PROTECT_BANK0, default 1, bank 0 is read-only from the data port unless prog_en=1.
REQ-002 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 prog_en  in  1  programming mode; lifts bank-0 write protection.
REQ-005 d_req  in  1  data-port request, one access per cycle.
REQ-006 d_we  in  1  1=write, 0=read; sampled with d_req.
REQ-007 d_addr  in  ADDR_W  data byte address.
REQ-008 d_wdata  in  DATA_W  write data.
REQ-009 d_rdata  out  DATA_W  read data, valid while d_ack=1.
REQ-010 d_ack  out  1  one-cycle response strobe.
REQ-011 d_err  out  1  error flag, qualified by d_ack.
REQ-012 i_req  in  1  instruction fetch request.
REQ-013 i_addr  in  ADDR_W  fetch byte address.
REQ-014 i_rdata  out  DATA_W  fetched word, valid while i_valid=1.
REQ-015 i_valid  out  1  one-cycle fetch strobe.
REQ-016 busy  out  1  1 while the clear sweep runs.

Function
REQ-017 Address decode SHALL be: bank = addr[ADDR_W-1 -: log2(NUM_BANKS)]; word index = the bits between the bank field and bit 0; bit 0 is the byte offset.
REQ-018 Each bank SHALL hold 2^(ADDR_W-1-log2(NUM_BANKS)) words (default 512).
REQ-019 Data port SHALL respond exactly 1 cycle after an accepted d_req (d_ack=1 for one cycle) and SHALL accept back-to-back requests every cycle.
REQ-020 A read SHALL return the stored word on d_rdata with d_err=0.
REQ-021 A write SHALL update the word at the clock edge that accepts it and SHALL respond with d_ack=1, d_err=0; d_rdata is don't-care.
REQ-022 An access with addr[0]=1 SHALL not modify memory and SHALL respond d_ack=1, d_err=1, d_rdata=0.
REQ-023 A write to bank 0 with PROTECT_BANK0=1 and prog_en=0 SHALL be dropped and SHALL respond d_err=1.
REQ-024 A fetch SHALL return the word 1 cycle after i_req with i_valid=1; addr[0] is ignored; all banks are fetchable.
REQ-025 When a fetch and a data write target the same word in the same cycle, the fetch SHALL return the pre-write value.
REQ-026 When a data read and a data write to the same word occur on consecutive cycles, the read SHALL return the newly written value.
REQ-027 FSM states SHALL be CLEAR and IDLE. CLEAR zeroes word index k of every bank in parallel on cycle k, with busy=1, and ignores d_req and i_req (no ack/valid). After the last index it goes to IDLE with busy=0.
REQ-028 Clear SHALL take exactly 2^(ADDR_W-1-log2(NUM_BANKS)) cycles; the index counter SHALL not wrap into a second sweep.

Reset
REQ-029 While rst_n=0: d_ack=0, d_err=0, d_rdata=0, i_valid=0, i_rdata=0, busy=1, clear counter=0, state=CLEAR.
REQ-030 Reset asserted mid-sweep or mid-access SHALL abort the sweep or access and restart the sweep from index 0 on release; any pending response is discarded.
REQ-031 Memory array contents SHALL be defined only by the clear sweep; the array itself has no reset.

Structure
REQ-032 A shared package SHALL hold the state enum (CLEAR, IDLE) and the functions deriving bank-select width and words-per-bank from the parameters.
REQ-033 One sub-module, mem_bank, SHALL implement a single bank: 1 write port, 2 synchronous read ports, read-before-write. It is instantiated NUM_BANKS times in a generate loop.

Verification
REQ-034 Release reset; hold d_req=1 -> busy=1 for 512 cycles, no d_ack; then busy=0; a read of 0x402 returns 0x0000.
REQ-035 Write 0xABCD to 0xFFC, then read 0xFFC on the next cycle -> d_ack at each, read d_rdata=0xABCD, d_err=0.
REQ-036 With prog_en=0, write 0x1234 to 0x010 -> d_err=1; a fetch of 0x010 returns 0x0000. With prog_en=1, repeat -> d_err=0; the fetch returns 0x1234.
REQ-037 Read 0x403 -> d_ack=1, d_err=1, d_rdata=0.
REQ-038 With 0x802 holding 0x1111, in the same cycle write 0x2222 to 0x802 and fetch 0x802 -> i_rdata=0x1111; the next fetch returns 0x2222.
REQ-039 Assert rst_n=0 at sweep cycle 100 -> outputs take their reset values; after release, busy stays high for a full 512 cycles.

Source files
------------

// File: rtl/banked_memory_pkg.sv
// Shared types and parameter-derived helpers for the banked memory.
package banked_memory_pkg;

  // CLEAR: zeroing sweep after reset. IDLE: servicing data and fetch ports.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Number of address bits that select a bank.
  function automatic int bank_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

  // Words per bank: byte address minus byte-offset bit minus bank field.
  function automatic int words_per_bank(input int addr_w, input int num_banks);
    return 1 << (addr_w - 1 - $clog2(num_banks));
  endfunction

endpackage

// File: rtl/banked_memory_if.sv
// Data port and instruction-fetch port of the banked memory.
//
// Handshake: there is no backpressure. A request (d_req / i_req) is taken in
// the cycle it is high, unless the memory is busy clearing, in which case it
// is silently ignored. Every taken request gets exactly one single-cycle
// strobe (d_ack / i_valid) on the following cycle; d_rdata, d_err and i_rdata
// are meaningful only while their strobe is high.
interface banked_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr,
    input  d_rdata, d_ack, d_err, i_rdata, i_valid
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr,
    output d_rdata, d_ack, d_err, i_rdata, i_valid
  );
endinterface

// File: rtl/banked_memory_mem_bank.sv
// One memory bank: a single write port and two registered read ports.
// Reads sample the array before a same-edge write lands (read-before-write).
module mem_bank #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  // Array write plus both read registers; no reset, contents come from the sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/banked_memory.sv
// Banked word memory with a data port (read/write, bank-0 protection,
// misalignment errors) and an instruction-fetch port. After reset a sweep
// zeroes every bank in parallel before any access is accepted.
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 12,
  parameter int NUM_BANKS     = 4,
  parameter bit PROTECT_BANK0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_en,
  output logic            busy,
  output state_e          dbg_state_o,
  banked_memory_if.slave  bus
);

  localparam int BANK_W = bank_w(NUM_BANKS);
  localparam int IDX_W  = ADDR_W - 1 - BANK_W;
  localparam int WPB    = words_per_bank(ADDR_W, NUM_BANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic               d_ack_q, d_ack_d;
  logic               d_err_q, d_err_d;
  logic [BANK_W-1:0]  d_bank_q, d_bank_d;
  logic               i_valid_q, i_valid_d;
  logic [BANK_W-1:0]  i_bank_q, i_bank_d;

  logic [BANK_W-1:0]  d_bank, i_bank;
  logic [IDX_W-1:0]   d_idx, i_idx;
  logic               misaligned, protect_hit, d_reject;

  logic [NUM_BANKS-1:0] bank_we;
  logic [IDX_W-1:0]     wr_idx;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W-1:0]    rd_a [NUM_BANKS];
  logic [DATA_W-1:0]    rd_b [NUM_BANKS];

  // Fetch ignores the byte offset.
  logic unused_i_lsb;
  assign unused_i_lsb = bus.i_addr[0];

  assign d_bank      = bus.d_addr[ADDR_W-1 -: BANK_W];
  assign d_idx       = bus.d_addr[ADDR_W-BANK_W-1:1];
  assign i_bank      = bus.i_addr[ADDR_W-1 -: BANK_W];
  assign i_idx       = bus.i_addr[ADDR_W-BANK_W-1:1];
  assign misaligned  = bus.d_addr[0];
  assign protect_hit = PROTECT_BANK0 && !prog_en && bus.d_we && (d_bank == '0);
  assign d_reject    = misaligned || protect_hit;

  // Next-state and response logic: sweep the clear index, then serve both ports.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_bank_d  = d_bank_q;
    i_valid_d = 1'b0;
    i_bank_d  = i_bank_q;
    if (state_q == CLEAR) begin
      // The index parks on the last word so the sweep never wraps.
      if (clr_idx_q == LAST_IDX) begin
        state_d = IDLE;
      end else begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
      end
    end else begin
      if (bus.d_req) begin
        d_ack_d  = 1'b1;
        d_err_d  = d_reject;
        d_bank_d = d_bank;
      end
      if (bus.i_req) begin
        i_valid_d = 1'b1;
        i_bank_d  = i_bank;
      end
    end
  end

  // Bank write steering: all banks during the sweep, else one accepted data write.
  always_comb begin
    bank_we = '0;
    wr_idx  = d_idx;
    wr_data = bus.d_wdata;
    if (!rst_n) begin
      bank_we = '0;
    end else if (state_q == CLEAR) begin
      bank_we = '1;
      wr_idx  = clr_idx_q;
      wr_data = '0;
    end else if (bus.d_req && bus.d_we && !d_reject) begin
      bank_we[d_bank] = 1'b1;
    end
  end

  // State, clear index and one-cycle response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_bank_q  <= '0;
      i_valid_q <= 1'b0;
      i_bank_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_bank_q  <= d_bank_d;
      i_valid_q <= i_valid_d;
      i_bank_q  <= i_bank_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk       (clk),
      .we_i      (bank_we[b]),
      .waddr_i   (wr_idx),
      .wdata_i   (wr_data),
      .raddr_a_i (d_idx),
      .rdata_a_o (rd_a[b]),
      .raddr_b_i (i_idx),
      .rdata_b_o (rd_b[b])
    );
  end

  // Read data is forced to zero outside a good response so errors and reset read as 0.
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = (d_ack_q && !d_err_q) ? rd_a[d_bank_q] : '0;
  assign bus.i_valid = i_valid_q;
  assign bus.i_rdata = i_valid_q ? rd_b[i_bank_q] : '0;
  assign busy        = (state_q == CLEAR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_banked_memory.sv
// Bench for banked_memory: reset and sweep checks, a table of data-port
// vectors, hand-written fetch/hazard sequences, a short random phase against
// a word model, and a mid-sweep reset.
module tb_banked_memory;
  import banked_memory_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   prog_en = 1'b0;
  logic   busy;
  state_e dbg_state;

  banked_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  banked_memory #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .NUM_BANKS     (4),
    .PROTECT_BANK0 (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_en     (prog_en),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .bus         (bus.slave)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {check_rdata, err, rdata}
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W-1:0] iexp_q[$];
  logic [DATA_W-1:0] model [int];
  logic [DATA_W+1:0] d_e;
  logic [DATA_W-1:0] i_e;

  typedef struct {
    logic              pe;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mget(input int k);
    return model.exists(k) ? model[k] : '0;
  endfunction

  // Scoreboard: pop one expectation per response strobe.
  always @(negedge clk) begin
    if (bus.d_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d_ack_unexpected: got ack with no request outstanding");
      end else begin
        d_e = exp_q.pop_front();
        check("d_err", 32'(bus.d_err), 32'(d_e[DATA_W]));
        if (d_e[DATA_W+1]) check("d_rdata", 32'(bus.d_rdata), 32'(d_e[DATA_W-1:0]));
      end
    end
    if (bus.i_valid === 1'b1) begin
      if (iexp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL i_valid_unexpected: got fetch strobe with no fetch outstanding");
      end else begin
        i_e = iexp_q.pop_front();
        check("i_rdata", 32'(bus.i_rdata), 32'(i_e));
      end
    end
  end

  // Driver: one cycle of stimulus on both ports, pushing expectations.
  task automatic cyc(input logic dv, input logic we, input logic pe,
                     input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd,
                     input logic e_err, input logic [DATA_W-1:0] e_rd,
                     input logic iv, input logic [ADDR_W-1:0] ia,
                     input logic [DATA_W-1:0] i_exp);
    @(posedge clk);
    #1;
    prog_en     = pe;
    bus.d_req   = dv;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.i_req   = iv;
    bus.i_addr  = ia;
    if (iv) iexp_q.push_back(i_exp);
    if (dv) begin
      exp_q.push_back({(!we || e_err), e_err, (e_err ? {DATA_W{1'b0}} : e_rd)});
      if (we && !e_err) model[int'(da >> 1)] = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, '0, 0, '0, '0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(busy),        32'd1);
    check({tag, "_d_ack"},   32'(bus.d_ack),   32'd0);
    check({tag, "_d_err"},   32'(bus.d_err),   32'd0);
    check({tag, "_d_rdata"}, 32'(bus.d_rdata), 32'd0);
    check({tag, "_i_valid"}, 32'(bus.i_valid), 32'd0);
    check({tag, "_i_rdata"}, 32'(bus.i_rdata), 32'd0);
    check({tag, "_state"},   32'(dbg_state),   32'(CLEAR));
  endtask

  initial begin
    int n;
    logic [1:0] rb, ib;
    logic [2:0] ri, ii;
    logic lsb, rwe, rpe, rerr, riv;
    logic [ADDR_W-1:0] ra, ria;
    logic [DATA_W-1:0] rwd, rrd;

    //                pe  we  addr     wdata     err  rdata
    vecs[0]  = '{1'b0, 1'b0, 12'h402, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 12'hFFC, 16'hABCD, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 12'hFFC, 16'h0000, 1'b0, 16'hABCD};
    vecs[3]  = '{1'b0, 1'b1, 12'h030, 16'h5A5A, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 12'h030, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 12'h030, 16'h5A5A, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 12'h030, 16'h0000, 1'b0, 16'h5A5A};
    vecs[7]  = '{1'b0, 1'b0, 12'h403, 16'h0000, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 12'h405, 16'h5555, 1'b1, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 12'h404, 16'h0000, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 12'h802, 16'h1111, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 12'h7FE, 16'h0BAD, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 12'h7FE, 16'h0000, 1'b0, 16'h0BAD};
    vecs[13] = '{1'b1, 1'b1, 12'h000, 16'hBEEF, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'hBEEF};
    vecs[15] = '{1'b0, 1'b0, 12'h001, 16'h0000, 1'b1, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 12'h3FE, 16'h7777, 1'b1, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 12'h3FE, 16'h0000, 1'b0, 16'h0000};
    vecs[18] = '{1'b1, 1'b0, 12'h3FE, 16'h0000, 1'b0, 16'h0000};
    vecs[19] = '{1'b0, 1'b0, 12'hC00, 16'h0000, 1'b0, 16'h0000};

    // Reset with requests held high; they must be ignored.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h402; bus.d_wdata = '0;
    bus.i_req = 1'b1; bus.i_addr = 12'h402;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // First sweep: requests stay asserted, no strobe may appear.
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(n);
    check("sweep1_len", 32'(n), 32'd512);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;

    // Table-driven data-port vectors, back to back.
    foreach (vecs[i])
      cyc(1, vecs[i].we, vecs[i].pe, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_err, vecs[i].exp_rd, 0, '0, '0);
    idle(2);

    // Bank-0 protection seen from the fetch port.
    cyc(1, 1, 0, 12'h010, 16'h1234, 1, '0, 0, '0, '0);
    cyc(0, 0, 0, '0, '0, 0, '0, 1, 12'h010, 16'h0000);
    cyc(1, 1, 1, 12'h010, 16'h1234, 0, '0, 0, '0, '0);
    cyc(0, 0, 0, '0, '0, 0, '0, 1, 12'h011, 16'h1234);

    // Same-cycle write and fetch of one word: fetch sees the old value.
    cyc(1, 1, 0, 12'h802, 16'h2222, 0, '0, 1, 12'h802, 16'h1111);
    cyc(0, 0, 0, '0, '0, 0, '0, 1, 12'h802, 16'h2222);
    idle(2);

    // Random traffic on a few words per bank against the model.
    for (int k = 0; k < 60; k++) begin
      rb  = 2'($urandom_range(0, 3));
      ri  = 3'($urandom_range(0, 7));
      lsb = ($urandom_range(0, 9) == 0);
      rwe = 1'($urandom_range(0, 1));
      rpe = 1'($urandom_range(0, 1));
      rwd = 16'($urandom_range(0, 65535));
      ra  = {rb, 6'd0, ri, lsb};
      ib  = 2'($urandom_range(0, 3));
      ii  = 3'($urandom_range(0, 7));
      riv = 1'($urandom_range(0, 1));
      ria = {ib, 6'd0, ii, 1'($urandom_range(0, 1))};
      rerr = lsb || (rwe && !rpe && rb == 2'd0);
      rrd  = (rerr || rwe) ? '0 : mget(int'(ra >> 1));
      cyc(1, rwe, rpe, ra, rwd, rerr, rrd, riv, ria, mget(int'(ria >> 1)));
    end
    idle(3);
    check("drain1_d", 32'(exp_q.size()), 32'd0);
    check("drain1_i", 32'(iexp_q.size()), 32'd0);

    // Reset at sweep cycle 100, with requests asserted.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model.delete();
    count_busy(n);
    check("sweep2_len", 32'(n), 32'd512);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;

    // Contents zeroed again by the restarted sweep.
    cyc(1, 0, 0, 12'h802, '0, 0, 16'h0000, 1, 12'hFFC, 16'h0000);
    cyc(1, 0, 0, 12'h000, '0, 0, 16'h0000, 1, 12'h030, 16'h0000);
    idle(3);
    check("drain2_d", 32'(exp_q.size()), 32'd0);
    check("drain2_i", 32'(iexp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
